// File: rtl/prometheus_fx3_gpif_if.sv
// FX3 GPIF-II slave FIFO pin stage: registers flags/data in, client strobes/data out,
// arbitrates loopback vs stream with a quiet drain between modes.
module prometheus_fx3_gpif_if #(
    parameter logic [1:0]  RD_ADDR      = 2'b11,
    parameter logic [1:0]  WR_ADDR      = 2'b00,
    parameter logic [1:0]  STREAM_ADDR  = 2'b00,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic [1:0]  mode_req,
    input  logic        fx3_flaga,
    input  logic        fx3_flagb,
    input  logic        fx3_flagc,
    input  logic        fx3_flagd,
    input  logic [31:0] fx3_data_i,
    output logic [31:0] fx3_data_o,
    output logic        fx3_data_oe,
    output logic [1:0]  fx3_addr,
    output logic        fx3_slrd_n,
    output logic        fx3_sloe_n,
    output logic        fx3_slwr_n,
    output logic        fx3_pktend_n,
    output logic        i_gpif_in_ch0_rdy_d,
    output logic        i_gpif_out_ch0_rdy_d,
    output logic        i_gpif_in_ch1_rdy_d,
    output logic        i_gpif_out_ch1_rdy_d,
    output logic        loopback_mode_selected,
    output logic        stream_mode_selected,
    output logic [31:0] data_in_loopback,
    input  logic        lb_re_n,
    input  logic        lb_oe_n,
    input  logic        lb_we_n,
    input  logic        lb_rd_addr_sel,
    input  logic [31:0] lb_data_out,
    input  logic        st_we_n,
    input  logic        st_pktend_n,
    input  logic [31:0] st_data_out,
    output logic [15:0] rd_word_cnt,
    output logic [15:0] wr_word_cnt,
    output logic        proto_err
);

    typedef enum logic [1:0] {StIdle, StLoopback, StStream, StDrain} state_e;
    typedef enum logic [1:0] {CliNone, CliLb, CliSt} client_e;

    localparam logic [3:0] QuietLast = 4'(QUIET_CYCLES - 1);

    state_e      state_q, state_d;
    client_e     client_q, client_d;
    logic [3:0]  quiet_q, quiet_d;
    logic        cnt_clear;
    logic        lb_route, st_route, client_quiet, conflict;
    logic        r_re_n, r_oe_n, r_we_n, r_pktend_n;
    logic [31:0] r_data;
    logic [1:0]  r_addr;

    // State register
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            client_q <= CliNone;
            quiet_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            client_q <= client_d;
            quiet_q  <= quiet_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        client_d  = client_q;
        quiet_d   = 4'd0;
        cnt_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mode_req == 2'd1) begin
                    state_d   = StLoopback;
                    client_d  = CliLb;
                    cnt_clear = 1'b1;
                end else if (mode_req == 2'd2) begin
                    state_d   = StStream;
                    client_d  = CliSt;
                    cnt_clear = 1'b1;
                end
            end
            StLoopback: if (mode_req != 2'd1) state_d = StDrain;
            StStream:   if (mode_req != 2'd2) state_d = StDrain;
            StDrain: begin
                // Any active strobe of the latched client restarts the quiet count.
                if (client_quiet) begin
                    if (quiet_q == QuietLast) begin
                        state_d  = StIdle;
                        client_d = CliNone;
                    end else begin
                        quiet_d = quiet_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / routing logic
    always_comb begin
        loopback_mode_selected = (state_q == StLoopback);
        stream_mode_selected   = (state_q == StStream);
        lb_route = (state_q == StLoopback) || ((state_q == StDrain) && (client_q == CliLb));
        st_route = (state_q == StStream) || ((state_q == StDrain) && (client_q == CliSt));

        unique case (client_q)
            CliLb:   client_quiet = lb_re_n & lb_oe_n & lb_we_n;
            CliSt:   client_quiet = st_we_n & st_pktend_n;
            default: client_quiet = 1'b1;
        endcase

        r_re_n     = 1'b1;
        r_oe_n     = 1'b1;
        r_we_n     = 1'b1;
        r_pktend_n = 1'b1;
        r_data     = 32'd0;
        r_addr     = WR_ADDR;
        if (lb_route) begin
            r_re_n = lb_re_n;
            r_oe_n = lb_oe_n;
            r_we_n = lb_we_n;
            r_data = lb_data_out;
            r_addr = lb_rd_addr_sel ? RD_ADDR : WR_ADDR;
        end else if (st_route) begin
            r_we_n     = st_we_n;
            r_pktend_n = st_pktend_n;
            r_data     = st_data_out;
            r_addr     = STREAM_ADDR;
        end
        conflict = ~r_oe_n & ~r_we_n;
    end

    // Pad and status registers
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            fx3_slrd_n           <= 1'b1;
            fx3_sloe_n           <= 1'b1;
            fx3_slwr_n           <= 1'b1;
            fx3_pktend_n         <= 1'b1;
            fx3_data_oe          <= 1'b0;
            fx3_data_o           <= 32'd0;
            fx3_addr             <= WR_ADDR;
            i_gpif_in_ch0_rdy_d  <= 1'b0;
            i_gpif_out_ch0_rdy_d <= 1'b0;
            i_gpif_in_ch1_rdy_d  <= 1'b0;
            i_gpif_out_ch1_rdy_d <= 1'b0;
            data_in_loopback     <= 32'd0;
            rd_word_cnt          <= 16'd0;
            wr_word_cnt          <= 16'd0;
            proto_err            <= 1'b0;
        end else begin
            fx3_slrd_n           <= r_re_n;
            fx3_sloe_n           <= r_oe_n;
            fx3_slwr_n           <= r_we_n | conflict;
            fx3_pktend_n         <= r_pktend_n;
            fx3_data_oe          <= ~r_we_n & ~conflict;
            fx3_addr             <= r_addr;
            if (!r_we_n) fx3_data_o <= r_data;
            i_gpif_in_ch0_rdy_d  <= fx3_flaga;
            i_gpif_out_ch0_rdy_d <= fx3_flagb;
            i_gpif_in_ch1_rdy_d  <= fx3_flagc;
            i_gpif_out_ch1_rdy_d <= fx3_flagd;
            data_in_loopback     <= fx3_data_i;
            if (conflict) proto_err <= 1'b1;
            if (cnt_clear) begin
                rd_word_cnt <= 16'd0;
                wr_word_cnt <= 16'd0;
            end else begin
                if (!fx3_slrd_n) rd_word_cnt <= rd_word_cnt + 16'd1;
                if (!fx3_slwr_n) wr_word_cnt <= wr_word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prometheus_fx3_gpif_if.sv
// Scoreboard bench for prometheus_fx3_gpif_if: per-cycle expected pad state is queued
// when stimulus is applied and compared one clock later.
module tb_prometheus_fx3_gpif_if;

    localparam logic [1:0] RdAddr = 2'b11;
    localparam logic [1:0] WrAddr = 2'b00;
    localparam logic [1:0] StAddr = 2'b00;
    localparam int unsigned Quiet = 4;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic [1:0]  mode_req;
    logic        fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd;
    logic [31:0] fx3_data_i, fx3_data_o, data_in_loopback;
    logic        fx3_data_oe;
    logic [1:0]  fx3_addr;
    logic        fx3_slrd_n, fx3_sloe_n, fx3_slwr_n, fx3_pktend_n;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic        loopback_mode_selected, stream_mode_selected;
    logic        lb_re_n, lb_oe_n, lb_we_n, lb_rd_addr_sel;
    logic [31:0] lb_data_out, st_data_out;
    logic        st_we_n, st_pktend_n;
    logic [15:0] rd_word_cnt, wr_word_cnt;
    logic        proto_err;

    typedef struct packed {
        logic [3:0]  strb;   // {slrd_n, sloe_n, slwr_n, pktend_n}
        logic        oe;
        logic [1:0]  addr;
        logic [31:0] dout;
        logic [31:0] din;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] exp_dout = 32'd0;
    bit          din_fixed = 1'b0;
    int          waited;

    always #5 clk_100 = ~clk_100;

    prometheus_fx3_gpif_if #(
        .RD_ADDR(RdAddr), .WR_ADDR(WrAddr), .STREAM_ADDR(StAddr), .QUIET_CYCLES(Quiet)
    ) dut (
        .clk_100(clk_100), .rst_n(rst_n), .mode_req(mode_req),
        .fx3_flaga(fx3_flaga), .fx3_flagb(fx3_flagb), .fx3_flagc(fx3_flagc),
        .fx3_flagd(fx3_flagd), .fx3_data_i(fx3_data_i), .fx3_data_o(fx3_data_o),
        .fx3_data_oe(fx3_data_oe), .fx3_addr(fx3_addr), .fx3_slrd_n(fx3_slrd_n),
        .fx3_sloe_n(fx3_sloe_n), .fx3_slwr_n(fx3_slwr_n), .fx3_pktend_n(fx3_pktend_n),
        .i_gpif_in_ch0_rdy_d(rdy0), .i_gpif_out_ch0_rdy_d(rdy1),
        .i_gpif_in_ch1_rdy_d(rdy2), .i_gpif_out_ch1_rdy_d(rdy3),
        .loopback_mode_selected(loopback_mode_selected),
        .stream_mode_selected(stream_mode_selected), .data_in_loopback(data_in_loopback),
        .lb_re_n(lb_re_n), .lb_oe_n(lb_oe_n), .lb_we_n(lb_we_n),
        .lb_rd_addr_sel(lb_rd_addr_sel), .lb_data_out(lb_data_out),
        .st_we_n(st_we_n), .st_pktend_n(st_pktend_n), .st_data_out(st_data_out),
        .rd_word_cnt(rd_word_cnt), .wr_word_cnt(wr_word_cnt), .proto_err(proto_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push expectation for the stimulus currently applied, clock once, pop and compare.
    task automatic cycle(input logic [3:0] strb, input logic oe, input logic [1:0] addr,
                         input string tag);
        exp_t e, g;
        {fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd} = 4'($urandom);
        if (!din_fixed) fx3_data_i = $urandom;
        e = '{strb: strb, oe: oe, addr: addr, dout: exp_dout, din: fx3_data_i,
              flags: {fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd}};
        sb_q.push_back(e);
        @(posedge clk_100);
        #1;
        e = sb_q.pop_front();
        g = '{strb: {fx3_slrd_n, fx3_sloe_n, fx3_slwr_n, fx3_pktend_n}, oe: fx3_data_oe,
              addr: fx3_addr, dout: fx3_data_o, din: data_in_loopback,
              flags: {rdy0, rdy1, rdy2, rdy3}};
        check_eq({tag, "_strb"}, 64'(g.strb), 64'(e.strb));
        check_eq({tag, "_oe"}, 64'(g.oe), 64'(e.oe));
        check_eq({tag, "_addr"}, 64'(g.addr), 64'(e.addr));
        check_eq({tag, "_dout"}, 64'(g.dout), 64'(e.dout));
        check_eq({tag, "_din"}, 64'(g.din), 64'(e.din));
        check_eq({tag, "_flags"}, 64'(g.flags), 64'(e.flags));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode_req = 2'd0;
        {fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd} = 4'b1111;
        fx3_data_i = 32'hDEAD_BEEF;
        lb_re_n = 1'b1; lb_oe_n = 1'b1; lb_we_n = 1'b1; lb_rd_addr_sel = 1'b0;
        lb_data_out = 32'd0; st_we_n = 1'b1; st_pktend_n = 1'b1; st_data_out = 32'd0;
        repeat (3) @(posedge clk_100);
        #1;
        check_eq("rst_strb", 64'({fx3_slrd_n, fx3_sloe_n, fx3_slwr_n, fx3_pktend_n}), 64'hF);
        check_eq("rst_oe", 64'(fx3_data_oe), 64'd0);
        check_eq("rst_addr", 64'(fx3_addr), 64'(WrAddr));
        check_eq("rst_flags", 64'({rdy0, rdy1, rdy2, rdy3}), 64'd0);
        check_eq("rst_din", 64'(data_in_loopback), 64'd0);
        check_eq("rst_cnt", 64'({rd_word_cnt, wr_word_cnt}), 64'd0);
        check_eq("rst_err", 64'(proto_err), 64'd0);
        rst_n = 1'b1;

        // Idle: flags and data toggle, pads stay quiet.
        for (int i = 0; i < 6; i++) cycle(4'hF, 1'b0, WrAddr, "idle");

        // Enter loopback, then 8 reads from the read socket.
        mode_req = 2'd1;
        cycle(4'hF, 1'b0, WrAddr, "lb_enter");
        check_eq("lb_sel", 64'(loopback_mode_selected), 64'd1);
        lb_re_n = 1'b0; lb_oe_n = 1'b0; lb_rd_addr_sel = 1'b1; din_fixed = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fx3_data_i = 32'(i);
            cycle(4'b0011, 1'b0, RdAddr, "lb_rd");
        end
        lb_re_n = 1'b1; lb_oe_n = 1'b1; lb_rd_addr_sel = 1'b0; din_fixed = 1'b0;
        cycle(4'hF, 1'b0, WrAddr, "lb_rd_end");
        check_eq("rd_cnt8", 64'(rd_word_cnt), 64'd8);

        // Loopback writes A0..A3.
        lb_we_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lb_data_out = 32'hA0 + 32'(i);
            exp_dout = lb_data_out;
            cycle(4'b1101, 1'b1, WrAddr, "lb_wr");
        end
        lb_we_n = 1'b1; lb_data_out = 32'h5555_5555;
        cycle(4'hF, 1'b0, WrAddr, "lb_wr_end");
        check_eq("wr_cnt4", 64'(wr_word_cnt), 64'd4);
        check_eq("err_clean", 64'(proto_err), 64'd0);

        // Switch to stream while loopback still writes: drain passes the writes.
        mode_req = 2'd2; lb_we_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lb_data_out = 32'hB0 + 32'(i);
            exp_dout = lb_data_out;
            cycle(4'b1101, 1'b1, WrAddr, "drain_wr");
            check_eq("drain_lbsel", 64'(loopback_mode_selected), 64'd0);
        end
        lb_we_n = 1'b1;
        waited = 0;
        while (!stream_mode_selected && waited < 30) begin
            cycle(4'hF, 1'b0, WrAddr, "drain_q");
            waited++;
        end
        check_eq("drain_len", 64'(waited), 64'(Quiet + 1));
        check_eq("st_cnt_clr", 64'({rd_word_cnt, wr_word_cnt}), 64'd0);

        // Stream: two words, packet end on the second; loopback strobes ignored.
        lb_re_n = 1'b0; lb_we_n = 1'b0;
        cycle(4'hF, 1'b0, StAddr, "st_ignore_lb");
        lb_re_n = 1'b1; lb_we_n = 1'b1;
        st_we_n = 1'b0; st_data_out = 32'hC0; exp_dout = 32'hC0;
        cycle(4'b1101, 1'b1, StAddr, "st_w0");
        st_pktend_n = 1'b0; st_data_out = 32'hC1; exp_dout = 32'hC1;
        cycle(4'b1100, 1'b1, StAddr, "st_w1");
        st_we_n = 1'b1; st_pktend_n = 1'b1;
        cycle(4'hF, 1'b0, StAddr, "st_end");
        check_eq("st_wr_cnt", 64'(wr_word_cnt), 64'd2);

        // Back to loopback, then a turnaround violation.
        mode_req = 2'd1;
        waited = 0;
        while (!loopback_mode_selected && waited < 30) begin
            cycle(4'hF, 1'b0, WrAddr, "to_lb");
            waited++;
        end
        check_eq("to_lb_len", 64'(waited), 64'(Quiet + 2));
        lb_oe_n = 1'b0; lb_we_n = 1'b0; lb_data_out = 32'hD0; exp_dout = 32'hD0;
        cycle(4'b1011, 1'b0, WrAddr, "turn");
        check_eq("turn_err", 64'(proto_err), 64'd1);
        lb_oe_n = 1'b1; lb_we_n = 1'b1;
        cycle(4'hF, 1'b0, WrAddr, "turn_rel");
        cycle(4'hF, 1'b0, WrAddr, "turn_rel2");
        check_eq("turn_sticky", 64'(proto_err), 64'd1);

        // Reset mid-write returns everything to reset values at once.
        lb_we_n = 1'b0; lb_data_out = 32'hE0; exp_dout = 32'hE0;
        cycle(4'b1101, 1'b1, WrAddr, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_strb", 64'({fx3_slrd_n, fx3_sloe_n, fx3_slwr_n, fx3_pktend_n}),
                 64'hF);
        check_eq("mid_rst_oe", 64'(fx3_data_oe), 64'd0);
        check_eq("mid_rst_dout", 64'(fx3_data_o), 64'd0);
        check_eq("mid_rst_err", 64'(proto_err), 64'd0);
        check_eq("mid_rst_sel", 64'(loopback_mode_selected), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/prometheus_fx3_gpif_if.md
Name: prometheus_fx3_gpif_if

Overview:
Pin-side stage between the FX3 GPIF-II slave FIFO pads and the mode clients: the loopback controller and the FPGA-to-host stream writer. Registers FX3 flags and read data into the client domain (producing the *_rdy_d flags and data_in_loopback), and registers client strobes, address and write data onto the pads. Owns mode arbitration with a safe drain between modes, bus turnaround protection and debug word counters.

Parameters:
RD_ADDR, 2'b11, FX3 socket address used while loopback selects its read socket.
WR_ADDR, 2'b00, FX3 socket address for loopback writes.
STREAM_ADDR, 2'b00, FX3 socket address for stream writes.
QUIET_CYCLES, 4, consecutive strobe-idle cycles required in DRAIN before returning to IDLE (range 1..15).

Ports:
clk_100  in  1  system clock; sole clock
rst_n  in  1  asynchronous active-low reset
mode_req  in  2  0 idle, 1 loopback, 2 stream, 3 treated as idle
fx3_flaga, fx3_flagb, fx3_flagc, fx3_flagd  in  1 each  raw FX3 flags
fx3_data_i  in  32  FX3 data bus input (from pad)
fx3_data_o  out  32  FX3 data bus output (to pad)
fx3_data_oe  out  1  pad output enable, 1 = FPGA drives
fx3_addr  out  2  FX3 socket address
fx3_slrd_n, fx3_sloe_n, fx3_slwr_n, fx3_pktend_n  out  1 each  FX3 strobes, active low
i_gpif_in_ch0_rdy_d, i_gpif_out_ch0_rdy_d, i_gpif_in_ch1_rdy_d, i_gpif_out_ch1_rdy_d  out  1 each  registered flaga/flagb/flagc/flagd
loopback_mode_selected  out  1  state == LOOPBACK
stream_mode_selected  out  1  state == STREAM
data_in_loopback  out  32  registered fx3_data_i
lb_re_n, lb_oe_n, lb_we_n, lb_rd_addr_sel  in  1 each  loopback client strobes and read-address select
lb_data_out  in  32  loopback write data
st_we_n, st_pktend_n  in  1 each  stream client strobes
st_data_out  in  32  stream write data
rd_word_cnt, wr_word_cnt  out  16 each  words read from / written to FX3
proto_err  out  1  sticky turnaround violation

Behaviour:
- Reset: all strobes 1, fx3_data_oe 0, fx3_data_o 0, fx3_addr WR_ADDR, rdy_d flags 0, data_in_loopback 0, counters 0, proto_err 0, state IDLE, active client none.
- Input path: one register stage on flags and data; data_in_loopback(t+1) = fx3_data_i(t).
- Output path: one register stage; pad strobes, addr, data_o, data_oe reflect client inputs of the previous cycle.
- Mode FSM, states IDLE, LOOPBACK, STREAM, DRAIN:
  - IDLE: mode_req 1 -> LOOPBACK; 2 -> STREAM; else stay. On entry, word counters clear.
  - LOOPBACK or STREAM: mode_req differs from the current mode -> DRAIN. The active client is latched on entry.
  - DRAIN: quiet counter increments when all strobes of the latched client are 1. It clears to 0 on any active strobe. At QUIET_CYCLES -> IDLE.
- Routing: only the latched client's strobes pass, in its own state and in DRAIN. In IDLE, all pad strobes are 1 and data_oe is 0. Stream client strobes are ignored in loopback and the reverse.
- Address, loopback client: RD_ADDR when lb_rd_addr_sel = 1, else WR_ADDR. Stream client: STREAM_ADDR.
- fx3_data_oe is the registered (client we_n == 0). fx3_data_o takes the selected client data when we_n == 0, else it holds.
- Turnaround: if the routed oe_n and we_n are both low in the same cycle:
  - sloe_n and slrd_n pass.
  - slwr_n is forced to 1 and data_oe to 0.
  - proto_err sets and stays set until reset.
- fx3_pktend_n: the registered st_pktend_n, in stream routing only.
- rd_word_cnt increments on each cycle with registered slrd_n == 0. wr_word_cnt increments on each cycle with registered slwr_n == 0. Both wrap 0xFFFF -> 0.
- mode_req change while in DRAIN: ignored until IDLE is reached.
- Reset mid-transfer: immediate return to the reset values.

Test Plan:
- Reset release with mode_req=0 and all flags toggling -> strobes stay 1, data_oe 0, rdy_d flags follow the raw flags 1 cycle late.
- mode_req=1, lb_re_n=lb_oe_n=0, lb_rd_addr_sel=1 for 8 cycles, fx3_data_i counting 0..7 -> fx3_addr=3 and slrd_n low 1 cycle after the client, data_in_loopback 0..7 delayed 1 cycle, rd_word_cnt=8.
- Loopback write: lb_we_n low for 4 cycles with data A0..A3 -> slwr_n and data_oe low/high for exactly 4 cycles, fx3_data_o A0..A3, wr_word_cnt=4.
- mode_req 1 -> 2 while lb_we_n is still low for 3 cycles -> DRAIN passes the loopback writes. IDLE is reached 3+QUIET_CYCLES cycles later, then STREAM. Counters are 0 on entry.
- Stream: st_we_n low for 2 words with st_pktend_n low on the second -> fx3_pktend_n low coincident with the second slwr_n, addr=0.
- lb_oe_n and lb_we_n low in the same cycle -> slwr_n stays 1, data_oe 0, proto_err=1 and it persists after the strobes release.
